// File: rtl/gfx_pkg.sv
// Shared screen geometry, colours, FSM encodings and the plot record for the
// sprite drawing path.
package gfx_pkg;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 15;
  localparam int PLOT_W     = 19;

  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_YELLOW = 3'b110;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_CLEAR      = 2'd1,
    S_CLEAR_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] colour;
    logic [7:0] y;
    logic [7:0] x;
  } plot_t;

  // y*160 + x as shift-and-add; only valid for on-screen coordinates.
  function automatic logic [ADDR_W-1:0] pixel_addr(logic [7:0] x, logic [7:0] y);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    return (yw << 7) + (yw << 5) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/pixel_write_sink_if.sv
// Plot stream (drawer -> sink) and framebuffer write port (sink -> memory).
// Both channels: a transfer happens on a rising edge where valid and ready are high.
interface pixel_write_sink_if;
  import gfx_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_x;
  logic [7:0]        in_y;
  logic [2:0]        in_colour;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_data;
  logic              mem_ready;

  modport slave (
    input  in_valid, in_x, in_y, in_colour, mem_ready,
    output in_ready, mem_we, mem_addr, mem_data
  );

  modport master (
    output in_valid, in_x, in_y, in_colour, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO holding raw plot records; pointers carry a wrap bit
// so full and empty are distinguishable.
module pixel_fifo
  import gfx_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = PLOT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/pixel_write_sink.sv
// Consumes sprite plots, clips off-screen ones, and writes surviving pixels or a
// full-screen clear sweep through a single stallable output register.
module pixel_write_sink
  import gfx_pkg::*;
(
  input  logic                      clk,
  input  logic                      resetn,
  pixel_write_sink_if.slave         bus,
  input  logic                      clear_req,
  input  logic [2:0]                clear_colour,
  output logic                      clear_done,
  output logic                      busy,
  output logic [7:0]                drop_count,
  output state_t                    fsm_state
);
  localparam logic [7:0] W8 = 8'(SCREEN_W);
  localparam logic [7:0] H8 = 8'(SCREEN_H);

  state_t            state;
  logic              clear_pending;
  logic [2:0]        clear_col;
  logic [ADDR_W-1:0] sweep_cnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_data;

  logic  fifo_full, fifo_empty;
  logic  push, pop, load_ok, on_screen;
  plot_t head;

  // Output register may load when empty or when its current write completes.
  assign load_ok   = !mem_we || bus.mem_ready;
  assign bus.in_ready = !fifo_full && !clear_pending && (state == S_IDLE);
  assign push      = bus.in_valid && bus.in_ready;
  assign pop       = (state == S_IDLE) && !fifo_empty && load_ok;
  assign on_screen = (head.x < W8) && (head.y < H8);

  pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PLOT_W)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .wdata  ({bus.in_colour, bus.in_y, bus.in_x}),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      clear_pending <= 1'b0;
      clear_col     <= '0;
      sweep_cnt     <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_data      <= '0;
      clear_done    <= 1'b0;
      drop_count    <= '0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clear_req && !clear_pending) begin
            clear_pending <= 1'b1;
            clear_col     <= clear_colour;
          end
          if (pop) begin
            if (on_screen) begin
              mem_we   <= 1'b1;
              mem_addr <= pixel_addr(head.x, head.y);
              mem_data <= head.colour;
            end else begin
              mem_we <= 1'b0;
              if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
          end else if (load_ok) begin
            mem_we <= 1'b0;
            // Queued plots always drain before the sweep starts.
            if (clear_pending && fifo_empty) begin
              state     <= S_CLEAR;
              sweep_cnt <= '0;
            end
          end
        end
        S_CLEAR: begin
          if (load_ok) begin
            mem_we   <= 1'b1;
            mem_addr <= sweep_cnt;
            mem_data <= clear_col;
            if (sweep_cnt == LAST_ADDR) state <= S_CLEAR_WAIT;
            else                        sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        S_CLEAR_WAIT: begin
          if (bus.mem_ready) begin
            mem_we        <= 1'b0;
            clear_done    <= 1'b1;
            clear_pending <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_we   = mem_we;
  assign bus.mem_addr = mem_addr;
  assign bus.mem_data = mem_data;
  assign busy         = clear_pending || (state != S_IDLE) || !fifo_empty || mem_we;
  assign fsm_state    = state;
endmodule
